// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  localparam logic [7:0] PS2_CODE_EXT = 8'hE0;
  localparam logic [7:0] PS2_CODE_BRK = 8'hF0;

  localparam int unsigned PS2_EVENT_W    = 10;
  localparam int unsigned PS2_EV_EXT_BIT = 9;
  localparam int unsigned PS2_EV_BRK_BIT = 8;

  function automatic logic [PS2_EVENT_W-1:0] ps2_make_event(input logic       ext,
                                                            input logic       brk,
                                                            input logic [7:0] code);
    logic [PS2_EVENT_W-1:0] ev;
    ev                 = {2'b00, code};
    ev[PS2_EV_EXT_BIT] = ext;
    ev[PS2_EV_BRK_BIT] = brk;
    return ev;
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy count and full/empty flags.
module ps2_sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CntW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: sync, clock filter, frame FSM, E0/F0 folding, event FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity or a low stop bit.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_ps2_clk,
  input  logic                            i_ps2_data,
  output logic [PS2_EVENT_W-1:0]          o_out_data,
  output logic                            o_out_valid,
  input  logic                            i_out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_fifo_count,
  output logic                            o_overflow,
  output logic                            o_frame_err
);

  localparam int unsigned FltW = $clog2(FILTER_LEN) + 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]             r_clk_sync;
  logic [1:0]             r_dat_sync;
  logic                   r_filt;
  logic [FltW-1:0]        r_flt_cnt;
  logic                   r_fall;
  ps2_state_e             r_state;
  logic [7:0]             r_shift;
  logic [2:0]             r_bit_cnt;
  logic [WdW-1:0]         r_wd;
  logic                   r_ext;
  logic                   r_brk;
  logic                   r_push;
  logic [PS2_EVENT_W-1:0] r_push_data;
  logic                   r_overflow;
  logic                   r_frame_err;
`ifdef PS2_PARITY_CHECK_EN
  logic                   r_parity;
`endif

  logic                   w_filt_next;
  logic [FltW-1:0]        w_flt_cnt_next;
  logic                   w_bit;
  logic                   w_timeout;
  ps2_state_e             w_state_next;
  logic                   w_frame_done;
  logic                   w_frame_ok;
  logic                   w_accept;
  logic                   w_reject;
  logic                   w_empty;
  logic                   w_full;

  assign w_bit = r_dat_sync[1];

  // Level moves only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    w_filt_next    = r_filt;
    w_flt_cnt_next = '0;
    if (r_clk_sync[1] != r_filt) begin
      if (r_flt_cnt == FltW'(FILTER_LEN - 1)) w_filt_next = r_clk_sync[1];
      else w_flt_cnt_next = r_flt_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_filt     <= 1'b1;
      r_flt_cnt  <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_data};
      r_filt     <= w_filt_next;
      r_flt_cnt  <= w_flt_cnt_next;
      r_fall     <= r_filt && !w_filt_next;
    end
  end

  assign w_timeout = (r_state != StIdle) && !r_fall && (r_wd == WdW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_timeout) begin
      w_state_next = StIdle;
    end else if (r_fall) begin
      unique case (r_state)
        StIdle:   if (!w_bit) w_state_next = StData;
        StData:   if (r_bit_cnt == 3'd7) w_state_next = StParity;
        StParity: w_state_next = StStop;
        StStop:   w_state_next = StIdle;
        default:  w_state_next = StIdle;
      endcase
    end
  end

  always_comb begin
    w_frame_done = r_fall && (r_state == StStop);
`ifdef PS2_PARITY_CHECK_EN
    w_frame_ok   = (^{r_shift, r_parity}) && w_bit;
`else
    w_frame_ok   = 1'b1;
`endif
    w_accept     = w_frame_done && w_frame_ok;
    w_reject     = w_frame_done && !w_frame_ok;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_wd        <= '0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_push      <= 1'b0;
      r_frame_err <= w_timeout || w_reject;
      r_wd        <= (r_state == StIdle || r_fall || w_timeout) ? '0 : r_wd + 1'b1;
      if (w_timeout) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
      if (r_fall) begin
        unique case (r_state)
          StIdle: begin
            if (!w_bit) begin
              r_shift   <= '0;
              r_bit_cnt <= '0;
            end
          end
          StData: begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          StParity: begin
`ifdef PS2_PARITY_CHECK_EN
            r_parity <= w_bit;
`endif
          end
          StStop: begin
            if (w_accept) begin
              if (r_shift == PS2_CODE_EXT) begin
                r_ext <= 1'b1;
              end else if (r_shift == PS2_CODE_BRK) begin
                r_brk <= 1'b1;
              end else begin
                r_push      <= 1'b1;
                r_push_data <= ps2_make_event(r_ext, r_brk, r_shift);
                r_ext       <= 1'b0;
                r_brk       <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_overflow <= 1'b0;
    else if (r_push && w_full && !(i_out_ready && !w_empty)) r_overflow <= 1'b1;
  end

  ps2_sync_fifo #(
    .WIDTH (PS2_EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (r_push),
    .i_data  (r_push_data),
    .i_pop   (i_out_ready),
    .o_data  (o_out_data),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (o_fifo_count)
  );

  assign o_out_valid = !w_empty;
  assign o_overflow  = r_overflow;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed self-checking bench for ps2_keyboard_rx (FIFO_DEPTH=4, FILTER_LEN=4).
module tb_ps2_keyboard_rx;

  localparam int unsigned Depth   = 4;
  localparam int unsigned Timeout = 2000;
  localparam int          Half    = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [9:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       frame_err;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_err   = 0;
  int         err0;
  logic [9:0] q_ev[$];

  ps2_keyboard_rx #(
    .FIFO_DEPTH     (Depth),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_out_data   (out_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_fifo_count (fifo_count),
    .o_overflow   (overflow),
    .o_frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) n_err++;
    if (out_valid && out_ready) q_ev.push_back(out_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Data settles while clk is high; pop_pulse raises out_ready for exactly the
  // cycle in which the FIFO write for this (stop) bit happens.
  task automatic ps2_bit(input logic b, input bit pop_pulse);
    ps2_data = b;
    repeat (Half) @(posedge clk);
    #1 ps2_clk = 1'b0;
    if (pop_pulse) begin
      repeat (7) @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      repeat (Half - 8) @(posedge clk);
    end else begin
      repeat (Half) @(posedge clk);
    end
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit flip_par, input bit pop_pulse);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i], 1'b0);
    ps2_bit((~^code) ^ flip_par, 1'b0);
    ps2_bit(1'b1, pop_pulse);
    ps2_data = 1'b1;
    repeat (Half) @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    out_ready = 1'b0;
    wait_cycles(4);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_fifo_count", 32'(fifo_count), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    wait_cycles(4);

    // Single make code, consumer always ready
    out_ready = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b0);
    check("a_events", 32'(q_ev.size()), 32'd1);
    if (q_ev.size() > 0) check("a_data", 32'(q_ev[0]), 32'h01C);
    check("a_count", 32'(fifo_count), 32'h0);

    // Extended break sequence folds into one event
    q_ev.delete();
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    check("ext_brk_no_prefix_event", 32'(q_ev.size()), 32'd0);
    send_frame(8'h75, 1'b0, 1'b0);
    check("ext_brk_events", 32'(q_ev.size()), 32'd1);
    if (q_ev.size() > 0) check("ext_brk_data", 32'(q_ev[0]), 32'h375);

    // Overflow: Depth+1 codes with no consumer
    q_ev.delete();
    out_ready = 1'b0;
    for (int i = 0; i < Depth + 1; i++) send_frame(8'h15, 1'b0, 1'b0);
    check("ovf_count", 32'(fifo_count), 32'(Depth));
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_head", 32'(out_data), 32'h015);
    check("ovf_head_stable", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    wait_cycles(10);
    out_ready = 1'b0;
    check("drain_events", 32'(q_ev.size()), 32'(Depth));
    foreach (q_ev[i]) check("drain_data", 32'(q_ev[i]), 32'h015);
    check("drain_count", 32'(fifo_count), 32'h0);
    check("ovf_sticky", 32'(overflow), 32'h1);

    // Reset mid-frame after a pending E0 prefix
    send_frame(8'hE0, 1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    rst_n = 1'b0;
    wait_cycles(3);
    check("midrst_overflow", 32'(overflow), 32'h0);
    check("midrst_count", 32'(fifo_count), 32'h0);
    rst_n    = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(4);
    q_ev.delete();
    out_ready = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b0);
    check("midrst_events", 32'(q_ev.size()), 32'd1);
    if (q_ev.size() > 0) check("midrst_data", 32'(q_ev[0]), 32'h01C);

    // Full FIFO: push and pop in the same cycle
    q_ev.delete();
    out_ready = 1'b0;
    for (int i = 0; i < Depth; i++) send_frame(8'(8'h11 + i), 1'b0, 1'b0);
    check("full_count", 32'(fifo_count), 32'(Depth));
    send_frame(8'h16, 1'b0, 1'b1);
    check("pp_count", 32'(fifo_count), 32'(Depth));
    check("pp_overflow", 32'(overflow), 32'h0);
    check("pp_popped", 32'(q_ev.size()), 32'd1);
    if (q_ev.size() > 0) check("pp_popped_data", 32'(q_ev[0]), 32'h011);
    out_ready = 1'b1;
    wait_cycles(10);
    check("pp_drain_events", 32'(q_ev.size()), 32'd5);
    if (q_ev.size() == 5) begin
      check("pp_order1", 32'(q_ev[1]), 32'h012);
      check("pp_order2", 32'(q_ev[2]), 32'h013);
      check("pp_order3", 32'(q_ev[3]), 32'h014);
      check("pp_tail", 32'(q_ev[4]), 32'h016);
    end

    // Flipped parity bit
    q_ev.delete();
    err0 = n_err;
    send_frame(8'h1C, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("par_err", 32'(n_err - err0), 32'd1);
    check("par_no_event", 32'(q_ev.size()), 32'd0);
`else
    check("par_no_err", 32'(n_err - err0), 32'd0);
    check("par_events", 32'(q_ev.size()), 32'd1);
    if (q_ev.size() > 0) check("par_data", 32'(q_ev[0]), 32'h01C);
`endif

    // Watchdog: start bit plus 4 data bits, then silence
    q_ev.delete();
    err0 = n_err;
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    wait_cycles(Timeout + 50);
    check("timeout_err", 32'(n_err - err0), 32'd1);
    check("timeout_no_event", 32'(q_ev.size()), 32'd0);

    // Single-cycle clock glitches with data low must not start a frame
    err0     = n_err;
    ps2_data = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 ps2_clk = 1'b0;
      @(posedge clk);
      #1 ps2_clk = 1'b1;
      wait_cycles(10);
    end
    ps2_data = 1'b1;
    wait_cycles(10);
    send_frame(8'h29, 1'b0, 1'b0);
    check("glitch_events", 32'(q_ev.size()), 32'd1);
    if (q_ev.size() > 0) check("glitch_data", 32'(q_ev[0]), 32'h029);
    check("glitch_no_err", 32'(n_err - err0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
